// File: rtl/vote_tally.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vote_tally: per-count tally of one-hot vote rounds over a session with a     |
// | majority verdict. Optional abort input under VOTE_TALLY_ABORT_EN.            |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module vote_tally #(
  parameter int CNT_W  = 8,
  parameter int ROUNDS = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
`ifdef VOTE_TALLY_ABORT_EN
  input  logic                          abort,
`endif
  input  logic                          r_valid,
  input  logic [3:0]                    r_in,
  output logic                          r_ready,
  output logic [CNT_W-1:0]              cnt0,
  output logic [CNT_W-1:0]              cnt1,
  output logic [CNT_W-1:0]              cnt2,
  output logic [CNT_W-1:0]              cnt3,
  output logic [$clog2(ROUNDS+1)-1:0]   rounds,
  output logic                          done,
  output logic                          pass,
  output logic                          err
);

  localparam int RW = $clog2(ROUNDS + 1);
  localparam logic [RW-1:0] C_LAST = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt0, r_cnt1, r_cnt2, r_cnt3;
  logic [CNT_W-1:0] w_cnt0_nx, w_cnt1_nx, w_cnt2_nx, w_cnt3_nx;
  logic [RW-1:0]    r_rounds;
  logic             r_pass;
  logic             r_err;
  logic             w_abort;
  logic             w_legal;
  logic             w_last;
  logic             w_pass_nx;
  logic             w_clear;
  logic             w_count;
  logic             w_fin;
  logic             w_bad;
  logic [CNT_W:0]   w_maj;
  logic [CNT_W:0]   w_min;

`ifdef VOTE_TALLY_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_legal = (r_in != 4'b0000) && ((r_in & (r_in - 4'd1)) == 4'b0000);
  assign w_last  = (r_rounds == C_LAST);

  assign w_cnt0_nx = r_cnt0 + CNT_W'(r_in[0]);
  assign w_cnt1_nx = r_cnt1 + CNT_W'(r_in[1]);
  assign w_cnt2_nx = r_cnt2 + CNT_W'(r_in[2]);
  assign w_cnt3_nx = r_cnt3 + CNT_W'(r_in[3]);

  // Verdict includes the token being accepted on the final edge.
  assign w_maj     = {1'b0, w_cnt2_nx} + {1'b0, w_cnt3_nx};
  assign w_min     = {1'b0, w_cnt0_nx} + {1'b0, w_cnt1_nx};
  assign w_pass_nx = (w_maj > w_min);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_clear    = 1'b0;
    w_count    = 1'b0;
    w_fin      = 1'b0;
    w_bad      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nx = S_COLLECT;
          w_clear    = 1'b1;
        end
      end
      S_COLLECT: begin
        if (w_abort) begin
          w_state_nx = S_IDLE;
          w_clear    = 1'b1;
        end else if (r_valid) begin
          if (w_legal) begin
            w_count = 1'b1;
            if (w_last) begin
              w_fin      = 1'b1;
              w_state_nx = S_DONE;
            end
          end else begin
            w_bad = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt0   <= '0;
      r_cnt1   <= '0;
      r_cnt2   <= '0;
      r_cnt3   <= '0;
      r_rounds <= '0;
      r_pass   <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_clear) begin
      r_cnt0   <= '0;
      r_cnt1   <= '0;
      r_cnt2   <= '0;
      r_cnt3   <= '0;
      r_rounds <= '0;
      r_pass   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_count) begin
        r_cnt0   <= w_cnt0_nx;
        r_cnt1   <= w_cnt1_nx;
        r_cnt2   <= w_cnt2_nx;
        r_cnt3   <= w_cnt3_nx;
        r_rounds <= r_rounds + RW'(1);
        if (w_fin) begin
          r_pass <= w_pass_nx;
        end
      end
      if (w_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign r_ready = (r_state == S_COLLECT);
  assign done    = (r_state == S_DONE);
  assign cnt0    = r_cnt0;
  assign cnt1    = r_cnt1;
  assign cnt2    = r_cnt2;
  assign cnt3    = r_cnt3;
  assign rounds  = r_rounds;
  assign pass    = r_pass;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vote_tally.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vote_tally: scoreboard bench for vote_tally (ROUNDS=9 main instance and   |
// | a ROUNDS=4 instance for the tie case). Revision: 1.0                         |
// +----------------------------------------------------------------------------+
module tb_vote_tally;

  localparam int CNT_W  = 8;
  localparam int ROUNDS = 9;

  typedef struct {
    int c0, c1, c2, c3, rnd;
    bit pass, err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       r_valid = 1'b0;
  logic [3:0] r_in = 4'b0000;

  logic             r_ready, done, pass, err;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
  logic [3:0]       rounds;
  logic             r_ready4, done4, pass4, err4;
  logic [CNT_W-1:0] cnt0_4, cnt1_4, cnt2_4, cnt3_4;
  logic [2:0]       rounds4;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  int   m_c[4];
  int   m_rnd;
  bit   m_err;
  logic prev_done = 1'b0;

  vote_tally #(.CNT_W(CNT_W), .ROUNDS(ROUNDS)) u_dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef VOTE_TALLY_ABORT_EN
    .abort(abort),
`endif
    .r_valid(r_valid), .r_in(r_in), .r_ready(r_ready),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
    .rounds(rounds), .done(done), .pass(pass), .err(err)
  );

  vote_tally #(.CNT_W(CNT_W), .ROUNDS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start),
`ifdef VOTE_TALLY_ABORT_EN
    .abort(abort),
`endif
    .r_valid(r_valid), .r_in(r_in), .r_ready(r_ready4),
    .cnt0(cnt0_4), .cnt1(cnt1_4), .cnt2(cnt2_4), .cnt3(cnt3_4),
    .rounds(rounds4), .done(done4), .pass(pass4), .err(err4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) m_c[k] = 0;
    m_rnd = 0;
    m_err = 1'b0;
  endtask

  task automatic start_session();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
  endtask

  // Offer one token after gap idle cycles; waits (bounded) for r_ready.
  task automatic send_tok(input logic [3:0] tok, input int gap);
    exp_t e;
    int   t;
    repeat (gap) @(negedge clk);
    r_valid = 1'b1;
    r_in    = tok;
    t = 0;
    while (!r_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!r_ready) check("ready_timeout", 32'd0, 32'd1);
    if ($countones(tok) == 1) begin
      for (int k = 0; k < 4; k++) if (tok[k]) m_c[k]++;
      m_rnd++;
      if (m_rnd == ROUNDS) begin
        e.c0 = m_c[0]; e.c1 = m_c[1]; e.c2 = m_c[2]; e.c3 = m_c[3];
        e.rnd  = m_rnd;
        e.pass = (m_c[2] + m_c[3]) > (m_c[0] + m_c[1]);
        e.err  = m_err;
        sb_q.push_back(e);
      end
    end else begin
      m_err = 1'b1;
    end
    @(negedge clk);
    r_valid = 1'b0;
    r_in    = 4'b0000;
  endtask

  // Scoreboard: compare a completed session when done rises.
  always @(negedge clk) begin
    prev_done <= done;
    if (done && !prev_done) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_cnt0", 32'(cnt0), 32'(e.c0));
        check("sb_cnt1", 32'(cnt1), 32'(e.c1));
        check("sb_cnt2", 32'(cnt2), 32'(e.c2));
        check("sb_cnt3", 32'(cnt3), 32'(e.c3));
        check("sb_rounds", 32'(rounds), 32'(e.rnd));
        check("sb_pass", 32'(pass), 32'(e.pass));
        check("sb_err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    model_clear();
    // Reset, then idle with a token offered: nothing accepted.
    r_valid = 1'b1;
    r_in    = 4'b0100;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(r_ready), 32'd0);
    check("idle_cnt2", 32'(cnt2), 32'd0);
    check("idle_rounds", 32'(rounds), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_err", 32'(err), 32'd0);
    r_valid = 1'b0;
    r_in    = 4'b0000;

    // Tie on the ROUNDS=4 instance: 2 minority vs 2 majority.
    start_session();
    send_tok(4'b0010, 0);
    send_tok(4'b0100, 0);
    send_tok(4'b0001, 0);
    send_tok(4'b1000, 0);
    check("tie_done", 32'(done4), 32'd1);
    check("tie_pass", 32'(pass4), 32'd0);
    check("tie_cnts", {cnt3_4, cnt2_4, cnt1_4, cnt0_4}, 32'h01010101);
    check("tie_rounds", 32'(rounds4), 32'd4);
    check("main4_rounds", 32'(rounds), 32'd4);
    check("main4_done", 32'(done), 32'd0);

    // Async reset off the clock edge mid-session.
    #2 rst = 1'b1;
    #1;
    check("arst_rounds", 32'(rounds), 32'd0);
    check("arst_cnts", {cnt3, cnt2, cnt1, cnt0}, 32'd0);
    check("arst_ready", 32'(r_ready), 32'd0);
    check("arst_done4", 32'(done4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();

    // Full majority session.
    start_session();
    for (int i = 0; i < 5; i++) send_tok(4'b0100, 0);
    for (int i = 0; i < 3; i++) send_tok(4'b1000, 0);
    send_tok(4'b0001, 0);
    check("maj_done_latency", 32'(done), 32'd1);
    check("maj_pass", 32'(pass), 32'd1);

    // Token after done is ignored.
    r_valid = 1'b1;
    r_in    = 4'b0100;
    repeat (3) @(negedge clk);
    r_valid = 1'b0;
    check("frozen_cnt2", 32'(cnt2), 32'd5);
    check("frozen_rounds", 32'(rounds), 32'd9);
    check("frozen_done", 32'(done), 32'd1);

    // Illegal tokens, then nine legal 0010 tokens with random gaps.
    start_session();
    send_tok(4'b0110, 0);
    send_tok(4'b0000, 0);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_rounds", 32'(rounds), 32'd0);
    for (int i = 0; i < ROUNDS; i++) send_tok(4'b0010, $urandom_range(0, 3));
    check("min_done", 32'(done), 32'd1);

    // start in DONE clears everything.
    start_session();
    check("restart_ready", 32'(r_ready), 32'd1);
    check("restart_err", 32'(err), 32'd0);
    check("restart_cnt1", 32'(cnt1), 32'd0);
    check("restart_done", 32'(done), 32'd0);

`ifdef VOTE_TALLY_ABORT_EN
    for (int i = 0; i < 4; i++) send_tok(4'b1000, 0);
    abort   = 1'b1;
    r_valid = 1'b1;
    r_in    = 4'b0100;
    @(negedge clk);
    abort   = 1'b0;
    r_valid = 1'b0;
    check("abort_ready", 32'(r_ready), 32'd0);
    check("abort_cnts", {cnt3, cnt2, cnt1, cnt0}, 32'd0);
    check("abort_rounds", 32'(rounds), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    start_session();
`endif

    // Random legal session with gaps.
    for (int i = 0; i < ROUNDS; i++) begin
      logic [3:0] tok;
      tok = 4'b0001 << $urandom_range(0, 3);
      send_tok(tok, $urandom_range(0, 2));
    end
    repeat (2) @(negedge clk);
    check("rand_done", 32'(done), 32'd1);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/vote_tally.md
Name: vote_tally

Overview:
- Downstream consumer of the 3-voter vote counter. Takes its one-hot result R[3:0] once per voting round and accumulates per-count tallies over a session of ROUNDS rounds.
- At end of session, declares whether majority rounds (2 or 3 yes votes) outnumbered minority rounds (0 or 1 yes votes).
- Sits between the combinational vote counter and the display/result logic.

Parameters:
- CNT_W, 8, width of each bucket counter; must satisfy ROUNDS < 2**CNT_W
- ROUNDS, 9, number of accepted rounds per session (>= 1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  begin new session (pulse)
- r_valid  input  1  r_in carries a round result
- r_in  input  4  one-hot vote count from upstream (bit k = k yes votes)
- r_ready  output  1  block accepts r_in this cycle
- cnt0  output  CNT_W  rounds with 0 yes votes
- cnt1  output  CNT_W  rounds with 1 yes vote
- cnt2  output  CNT_W  rounds with 2 yes votes
- cnt3  output  CNT_W  rounds with 3 yes votes
- rounds  output  $clog2(ROUNDS+1)  accepted rounds this session
- done  output  1  session complete, outputs stable
- pass  output  1  majority rounds > minority rounds; valid only while done=1
- err  output  1  sticky: an illegal (non-one-hot) r_in was offered

Behaviour:
- Reset (async, rst=1): state=IDLE; all counters, rounds, done, pass and err are 0; r_ready=0.
- FSM states: IDLE, COLLECT, DONE. r_ready=1 only in COLLECT (Moore, registered state).
- IDLE:
  - start=1 -> COLLECT next cycle.
  - Same edge clears cnt0..cnt3, rounds, err and pass.
- COLLECT:
  - Handshake: a transfer occurs on a clock edge with r_valid=1 and r_ready=1.
  - Legal r_in (exactly one bit set): the matching cntK increments and rounds increments on that edge. Visible the next cycle (1-cycle latency).
  - Illegal r_in (0000 or more than one bit set) with r_valid=1: token is consumed, nothing counted, rounds unchanged, err set to 1 (sticky until the next start).
  - When a legal transfer makes rounds reach ROUNDS: -> DONE on the same edge. pass is registered on that edge as (cnt2+cnt3) > (cnt0+cnt1), computed including the final token. A tie gives pass=0.
  - start while in COLLECT is ignored.
- DONE:
  - done=1; counters, rounds and pass are held; r_valid is ignored.
  - start=1 -> COLLECT with the same clears as in IDLE; done drops on that edge.
- done is 0 in IDLE and COLLECT.
- Counters cannot overflow, because the session terminates at ROUNDS. No wrap logic is required.
- Reset mid-session returns immediately to IDLE with all outputs 0. No partial results are retained.
- start and r_valid in the same cycle in IDLE/DONE: the token is not accepted, since r_ready=0 that cycle.

Optional Feature:
- Macro: VOTE_TALLY_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in COLLECT -> IDLE next edge, with counters, rounds, err and pass cleared. A token offered that same cycle is not counted.
  - abort has priority over a simultaneous transfer, including the final one.
  - abort is ignored in IDLE/DONE.
- Undefined: no abort port. A session can only be ended by completing ROUNDS transfers or by rst.

Test Plan:
- Reset then idle: rst pulse, r_valid=1 with r_in=0100 -> r_ready=0, all counts 0, done=0, err=0.
- Full majority session: start, then 9 transfers: 5×0100, 3×1000, 1×0001 -> cnt2=5, cnt3=3, cnt0=1, rounds=9, done=1 the cycle after the 9th transfer, pass=1.
- Minority/tie: ROUNDS=4, transfers 0010, 0100, 0001, 1000 -> 2 vs 2, done=1, pass=0.
- Illegal input: in COLLECT, offer r_in=0110, then 0000 -> err=1, rounds unchanged. Then 9 legal 0010 tokens -> cnt1=9, pass=0, err still 1. Next start clears err.
- Backpressure/idle gaps: r_valid low for random cycles between tokens; an extra token after done -> ignored, counts frozen. start in DONE -> counts 0 next cycle, r_ready=1.
- Async reset mid-session after 4 transfers (asserted off a clock edge) -> outputs 0 immediately. With VOTE_TALLY_ABORT_EN: abort after 4 transfers -> IDLE, counts 0, done=0.
